// File: rtl/vfd_pkg.sv
// Shared definitions for the host-to-GRAM receive path: command codes, FSM states, GRAM geometry.
// The HOST_RX_CHK_EN macro adds the checksum state used by host_frame_rx.
package vfd_pkg;

   localparam logic [7:0] CMD_FRAME = 8'h01;
   localparam logic [7:0] CMD_ADDR  = 8'h02;
   localparam logic [7:0] CMD_BLANK = 8'h03;

   localparam int GRAM_COLS_C  = 77;
   localparam int GRAM_ROWS_C  = 39;
   localparam int GRAM_DEPTH_C = GRAM_COLS_C * GRAM_ROWS_C;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR_HI,
      ST_ADDR_LO,
      ST_DATA,
      ST_BLANK,
      ST_DISCARD
`ifdef HOST_RX_CHK_EN
      , ST_CHK
`endif
   } rx_state_e;

endpackage

// File: rtl/in_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall strobes taken
// from the synchronized level. RST_VAL is the idle level of the line.
module in_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/host_frame_rx.sv
// Oversampled SPI slave (mode 0, MSB first) feeding the GRAM write port on the system clock.
// Define HOST_RX_CHK_EN to require a trailing XOR checksum byte on full frames.
module host_frame_rx
   import vfd_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int GRAM_DEPTH  = GRAM_DEPTH_C,
   parameter int ADDR_W      = 12
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              SSI,
   input  logic              SSCK,
   input  logic              SCS,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic              FRAME_ERR,
   output logic              DISP_EN,
   output logic              BUSY
);

   logic ssi_lvl, ssck_rise, scs_lvl, scs_rise, scs_fall;
   logic ssi_rise_unused, ssi_fall_unused, ssck_lvl_unused, ssck_fall_unused;

   in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ssi (
      .clk_i(CLK), .rst_ni(RST_N), .d_i(SSI),
      .q_o(ssi_lvl), .rise_o(ssi_rise_unused), .fall_o(ssi_fall_unused));
   in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ssck (
      .clk_i(CLK), .rst_ni(RST_N), .d_i(SSCK),
      .q_o(ssck_lvl_unused), .rise_o(ssck_rise), .fall_o(ssck_fall_unused));
   in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scs (
      .clk_i(CLK), .rst_ni(RST_N), .d_i(SCS),
      .q_o(scs_lvl), .rise_o(scs_rise), .fall_o(scs_fall));

   rx_state_e         state_q, state_d;
   logic [2:0]        bcnt_q;
   logic [7:0]        shift_q;
   logic [7:0]        byte_w;
   logic              bit_en, byte_done;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_lo;
   logic              mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              done_q, done_d, err_q, err_d, disp_q, disp_d;
`ifdef HOST_RX_CHK_EN
   logic [7:0]        chk_q, chk_d;
`else
   logic              full_q, full_d, pend_q, pend_d;
`endif

   // Bits are only taken while the host holds chip select low.
   assign bit_en    = ssck_rise & ~scs_lvl;
   assign byte_w    = {shift_q[6:0], ssi_lvl};
   assign byte_done = bit_en & (bcnt_q == 3'd7);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      disp_d  = disp_q;
`ifdef HOST_RX_CHK_EN
      chk_d   = chk_q;
`else
      full_d  = full_q;
      pend_d  = 1'b0;
`endif
      addr_lo = {addr_q[ADDR_W-1:8], byte_w};
      if (byte_done) begin
         case (state_q)
            ST_CMD: begin
               case (byte_w)
                  CMD_FRAME: begin
                     state_d = ST_DATA;
                     addr_d  = '0;
                     mode_d  = 1'b1;
`ifdef HOST_RX_CHK_EN
                     chk_d   = 8'h00;
`endif
                  end
                  CMD_ADDR: begin
                     state_d = ST_ADDR_HI;
                     mode_d  = 1'b0;
                  end
                  CMD_BLANK: state_d = ST_BLANK;
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_DISCARD;
                  end
               endcase
            end
            ST_ADDR_HI: begin
               addr_d  = {byte_w[ADDR_W-9:0], 8'h00};
               state_d = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
               if (addr_lo >= ADDR_W'(GRAM_DEPTH)) begin
                  err_d   = 1'b1;
                  state_d = ST_DISCARD;
               end else begin
                  addr_d  = addr_lo;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               wen_d   = 1'b1;
               waddr_d = addr_q;
               wdata_d = {2'b00, byte_w[5:0]};
`ifdef HOST_RX_CHK_EN
               chk_d   = chk_q ^ byte_w;
`endif
               // The last GRAM location ends the stream; the address never wraps.
               if (addr_q == ADDR_W'(GRAM_DEPTH - 1)) begin
                  state_d = ST_DISCARD;
                  if (mode_q) begin
`ifdef HOST_RX_CHK_EN
                     state_d = ST_CHK;
`else
                     full_d  = 1'b1;
`endif
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
            ST_BLANK: begin
               disp_d  = byte_w[0];
               state_d = ST_DISCARD;
            end
`ifdef HOST_RX_CHK_EN
            ST_CHK: begin
               done_d  = (byte_w == chk_q);
               err_d   = (byte_w != chk_q);
               state_d = ST_DISCARD;
            end
`endif
            default: ;
         endcase
      end
      if (scs_fall) begin
         state_d = ST_CMD;
         busy_d  = 1'b1;
`ifndef HOST_RX_CHK_EN
         full_d  = 1'b0;
`endif
      end
      if (scs_rise) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
`ifndef HOST_RX_CHK_EN
         // A frame finished by a byte landing with the SCS edge reports one cycle
         // later, so the pulse never overlaps that final write.
         done_d  = full_q;
         pend_d  = full_d & ~full_q;
`endif
      end
`ifndef HOST_RX_CHK_EN
      if (pend_q) done_d = 1'b1;
`endif
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         bcnt_q  <= '0;
         addr_q  <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         disp_q  <= 1'b1;
`ifndef HOST_RX_CHK_EN
         full_q  <= 1'b0;
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bcnt_q  <= (scs_fall | scs_rise) ? 3'd0 : (bit_en ? bcnt_q + 3'd1 : bcnt_q);
         addr_q  <= addr_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         disp_q  <= disp_d;
`ifndef HOST_RX_CHK_EN
         full_q  <= full_d;
         pend_q  <= pend_d;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (bit_en) shift_q <= byte_w;
`ifdef HOST_RX_CHK_EN
      chk_q <= chk_d;
`endif
   end

   assign W_EN       = wen_q;
   assign W_ADDR     = waddr_q;
   assign W_DATA     = wdata_q;
   assign FRAME_DONE = done_q;
   assign FRAME_ERR  = err_q;
   assign DISP_EN    = disp_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_host_frame_rx.sv
// Directed bench for host_frame_rx: SPI stimulus at CLK/4 with a write scoreboard and pulse counters.
// Uses a reduced GRAM depth so full frames stay short; honours HOST_RX_CHK_EN.
module tb_host_frame_rx;

   localparam int DEPTH  = 300;
   localparam int ADDR_W = 12;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              SSI = 1'b0;
   logic              SSCK = 1'b0;
   logic              SCS = 1'b1;
   logic [ADDR_W-1:0] W_ADDR;
   logic [7:0]        W_DATA;
   logic              W_EN, FRAME_DONE, FRAME_ERR, DISP_EN, BUSY;

   host_frame_rx #(.SYNC_STAGES(2), .GRAM_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .SSI(SSI), .SSCK(SSCK), .SCS(SCS),
      .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_EN(W_EN),
      .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .DISP_EN(DISP_EN), .BUSY(BUSY));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } wr_t;

   wr_t exp_q[$];
   int  n_chk = 0, n_pass = 0;
   int  wr_cnt = 0, done_cnt = 0, err_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: every GRAM write must match the oldest expected write.
   always @(negedge CLK) begin
      if (W_EN) begin
         wr_cnt++;
         if (exp_q.size() == 0) chk("unexpected_write", {20'h0, W_ADDR}, 32'hFFFF);
         else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("w_addr", W_ADDR, e.a);
            chk("w_data", W_DATA, e.d);
         end
      end
      if (FRAME_DONE) begin
         done_cnt++;
         chk("done_vs_wen", W_EN, 0);
      end
      if (FRAME_ERR) err_cnt++;
   end

   task automatic send_bit(input logic b);
      SSI = b;
      repeat (2) @(negedge CLK);
      SSCK = 1'b1;
      repeat (2) @(negedge CLK);
      SSCK = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic scs_lo();
      repeat ($urandom_range(2, 7)) @(negedge CLK);
      SCS = 1'b0;
      repeat (6) @(negedge CLK);
      chk("busy_high", BUSY, 1);
   endtask

   task automatic scs_hi();
      repeat ($urandom_range(3, 8)) @(negedge CLK);
      SCS = 1'b1;
      repeat (10) @(negedge CLK);
      chk("busy_low", BUSY, 0);
   endtask

   task automatic send_frame(output logic [7:0] x);
      logic [7:0] b;
      x = 8'h00;
      send_byte(8'h01);
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'(i % 64);
         x ^= b;
         exp_q.push_back('{a: ADDR_W'(i), d: b});
         send_byte(b);
      end
   endtask

   task automatic chk_counts(input string tag, input int w, input int d, input int e);
      chk({tag, "_writes"}, wr_cnt, w);
      chk({tag, "_done"}, done_cnt, d);
      chk({tag, "_err"}, err_cnt, e);
      chk({tag, "_queue"}, exp_q.size(), 0);
      wr_cnt = 0; done_cnt = 0; err_cnt = 0;
   endtask

   initial begin
      logic [7:0] x;
      int         ad;
      repeat (4) @(negedge CLK);
      chk("rst_wen", W_EN, 0);
      chk("rst_addr", W_ADDR, 0);
      chk("rst_data", W_DATA, 0);
      chk("rst_done", FRAME_DONE, 0);
      chk("rst_err", FRAME_ERR, 0);
      chk("rst_disp", DISP_EN, 1);
      chk("rst_busy", BUSY, 0);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);

      // Full frame; without the checksum option it completes on SCS rise.
      scs_lo();
      send_frame(x);
      scs_hi();
`ifdef HOST_RX_CHK_EN
      chk_counts("frame", DEPTH, 0, 0);
`else
      chk_counts("frame", DEPTH, 1, 0);
`endif

      // Random-mode write near the end of GRAM stops at the last location.
      ad = DEPTH - 2;
      scs_lo();
      send_byte(8'h02);
      send_byte(8'(ad >> 8));
      send_byte(8'(ad));
      exp_q.push_back('{a: ADDR_W'(ad), d: 8'h3F});
      exp_q.push_back('{a: ADDR_W'(ad + 1), d: 8'h12});
      send_byte(8'hFF);
      send_byte(8'h12);
      send_byte(8'h34);
      scs_hi();
      chk_counts("random", 2, 0, 0);

      // Out-of-range address, then an unknown command.
      ad = DEPTH;
      scs_lo();
      send_byte(8'h02);
      send_byte(8'(ad >> 8));
      send_byte(8'(ad));
      send_byte(8'h55);
      scs_hi();
      chk_counts("bad_addr", 0, 0, 1);
      scs_lo();
      send_byte(8'h7E);
      send_byte(8'h01);
      scs_hi();
      chk_counts("bad_cmd", 0, 0, 1);

      // Short frame with a trailing partial byte.
      scs_lo();
      send_byte(8'h01);
      for (int i = 0; i < 100; i++) begin
         exp_q.push_back('{a: ADDR_W'(i), d: 8'(i % 64)});
         send_byte(8'(i % 64));
      end
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      scs_hi();
      chk_counts("short", 100, 0, 0);

      // Display enable control.
      scs_lo(); send_byte(8'h03); send_byte(8'h00); scs_hi();
      chk("disp_off", DISP_EN, 0);
      scs_lo(); send_byte(8'h03); send_byte(8'h01); scs_hi();
      chk("disp_on", DISP_EN, 1);
      scs_lo(); send_byte(8'h03); send_byte(8'hFE); send_byte(8'h01); scs_hi();
      chk("disp_off2", DISP_EN, 0);
      chk_counts("blank", 0, 0, 0);

      // Reset in the middle of a frame.
      scs_lo();
      send_byte(8'h01);
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back('{a: ADDR_W'(i), d: 8'(i + 3)});
         send_byte(8'(i + 3));
      end
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_wen", W_EN, 0);
      chk("mid_rst_addr", W_ADDR, 0);
      chk("mid_rst_data", W_DATA, 0);
      chk("mid_rst_disp", DISP_EN, 1);
      chk("mid_rst_busy", BUSY, 0);
      SCS = 1'b1;
      repeat (4) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);
      chk_counts("mid_rst", 10, 0, 0);

`ifdef HOST_RX_CHK_EN
      scs_lo();
      send_frame(x);
      send_byte(x);
      scs_hi();
      chk_counts("chk_good", DEPTH, 1, 0);
      scs_lo();
      send_frame(x);
      send_byte(x ^ 8'h01);
      scs_hi();
      chk_counts("chk_bad", DEPTH, 0, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
